// File: rtl/draw_sequencer_pkg.sv
// draw_sequencer_pkg: shared state encoding, bus widths and index-width helper
package draw_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, GAP = 2'd2} state_t;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 9;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: drawer-side and VGA-side buses of the draw sequencer
interface draw_sequencer_if import draw_sequencer_pkg::*; #(parameter int NUM_SRC = 4);
  logic [NUM_SRC-1:0] draw_req;
  logic [NUM_SRC-1:0] src_done;
  logic [NUM_SRC*X_W-1:0] src_x;
  logic [NUM_SRC*Y_W-1:0] src_y;
  logic [NUM_SRC*COLOUR_W-1:0] src_colour;
  logic [NUM_SRC-1:0] src_enable;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [COLOUR_W-1:0] colour;
  logic plot;
  logic busy;
  logic [NUM_SRC-1:0] draw_done;
  modport master (
    output draw_req, src_done, src_x, src_y, src_colour,
    input  src_enable, x, y, colour, plot, busy, draw_done
  );
  modport slave (
    input  draw_req, src_done, src_x, src_y, src_colour,
    output src_enable, x, y, colour, plot, busy, draw_done
  );
endinterface

// File: rtl/draw_sequencer_arbiter.sv
// draw_priority_arbiter: fixed-priority pick of the lowest set request bit
module draw_priority_arbiter import draw_sequencer_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          req_any
);
  always_comb begin
    grant = req & (~req + N'(1));
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
    req_any = |req;
  end
endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: serialises redraw requests onto one VGA port, one drawer at a time
module draw_sequencer import draw_sequencer_pkg::*; #(
  parameter int NUM_SRC = 4,
  parameter int WARMUP  = 2
) (
  input logic clk,
  input logic reset,
  draw_sequencer_if.slave bus
);
  localparam int IW = idx_w(NUM_SRC);
  localparam int WW = idx_w(WARMUP + 1);
  state_t state, nstate;
  logic [NUM_SRC-1:0] pending, grant, act_oh, done_q;
  logic [IW-1:0] active, gidx;
  logic [WW-1:0] warm;
  logic req_any, warm_full, act_done, fin, load;
  draw_priority_arbiter #(.N(NUM_SRC), .IW(IW)) u_arb (
    .req(pending), .grant(grant), .idx(gidx), .req_any(req_any)
  );
  assign act_oh    = NUM_SRC'(1) << active;
  assign warm_full = warm == WW'(WARMUP);
  assign act_done  = bus.src_done[active];
  // a done seen before the pipeline is warm belongs to the previous draw
  assign fin       = state == DRAW && warm_full && act_done;
  assign load      = state != DRAW && req_any;
  always_comb begin
    nstate = state == DRAW ? (fin ? GAP : DRAW) : (req_any ? DRAW : IDLE);
    bus.src_enable = (state == DRAW && !act_done) ? act_oh : '0;
    bus.plot   = state == DRAW && warm_full;
    bus.x      = state == DRAW ? bus.src_x[active*X_W +: X_W] : '0;
    bus.y      = state == DRAW ? bus.src_y[active*Y_W +: Y_W] : '0;
    bus.colour = state == DRAW ? bus.src_colour[active*COLOUR_W +: COLOUR_W] : '0;
    bus.busy   = state != IDLE || |pending;
    bus.draw_done = done_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      active  <= '0;
      warm    <= '0;
      done_q  <= '0;
    end else begin
      state   <= nstate;
      pending <= (pending & ~(load ? grant : '0)) | bus.draw_req;
      active  <= load ? gidx : active;
      warm    <= load ? '0 : (state == DRAW && !warm_full) ? warm + 1'b1 : warm;
      done_q  <= fin ? act_oh : '0;
    end
  end
endmodule
